// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// It issues one WR per grant and follows the TxRDY low/high handshake. A watchdog then forces an Ack if TxRDY stalls.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ*DATA_W-1:0] ReqData,
  input  logic                   TxRDY,
  output logic                   WR,
  output logic [DATA_W-1:0]      TxData,
  output logic [NREQ-1:0]        Grant,
  output logic [NREQ-1:0]        Ack,
  output logic                   Busy,
  output logic                   TimeoutErr,
  input  logic                   ClrErr
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    idx_q, idx_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]   txdata_q, txdata_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                err_q, err_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic [NREQ-1:0]     ack_q, ack_d;

  logic                set_err;
  logic                found;
  logic [PTR_W-1:0]    cand;
  logic [PTR_W-1:0]    win;
  logic [NREQ-1:0]     win_onehot;
  logic [DATA_W-1:0]   win_data;

  // First requester at or after ptr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    win   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (!found && Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PTR_W'(i)) begin
        win_onehot[i] = 1'b1;
        win_data      = ReqData[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    grant_d  = grant_q;
    txdata_d = txdata_q;
    timer_d  = timer_q;
    set_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((|Req) && TxRDY) begin
          state_d  = S_WRITE;
          idx_d    = win;
          grant_d  = win_onehot;
          txdata_d = win_data;
          timer_d  = '0;
        end
      end
      S_WRITE: state_d = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!TxRDY) begin
          state_d = S_WAIT_HIGH;
        end else if (timer_q == TMR_LAST) begin
          set_err = 1'b1;
          state_d = S_ACK;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (TxRDY) begin
          state_d = S_ACK;
        end else if (timer_q == TMR_LAST) begin
          set_err = 1'b1;
          state_d = S_ACK;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = (idx_q == PTR_LAST) ? '0 : idx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A watchdog abort wins over a simultaneous clear.
    err_d  = set_err ? 1'b1 : (ClrErr ? 1'b0 : err_q);
    wr_d   = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
    ack_d  = (state_d == S_ACK) ? grant_d : '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      txdata_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      txdata_q <= txdata_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
    end
  end

  assign WR         = wr_q;
  assign TxData     = txdata_q;
  assign Grant      = grant_q;
  assign Ack        = ack_q;
  assign Busy       = busy_q;
  assign TimeoutErr = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the UART transmit path among NREQ byte sources. It latches the winning requester's byte and issues a one-cycle WR strobe to the transmit controller. It then tracks the TxRDY low/high handshake to frame completion and returns a per-requester Ack pulse. A watchdog aborts transactions when TxRDY does not respond. It sits between the software/DMA byte sources and the UART transmit controller plus shift register.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, byte width forwarded to transmitter
TIMEOUT_CYC, 1024, max Clock cycles from WR to TxRDY return before abort (>= 4)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  reset; synchronous, active-high
Req  in  NREQ  level request per source; held until matching Ack
ReqData  in  NREQ*DATA_W  packed bytes; source i at [i*DATA_W +: DATA_W]
TxRDY  in  1  transmitter ready (1 = idle, drops after WR, returns at frame end)
WR  out  1  one-cycle write strobe to transmitter
TxData  out  DATA_W  latched byte, stable from WR until next grant
Grant  out  NREQ  one-hot current owner, held from grant through Ack cycle
Ack  out  NREQ  one-cycle completion pulse to granted source
Busy  out  1  high in every state except IDLE
TimeoutErr  out  1  sticky watchdog error flag
ClrErr  in  1  clears TimeoutErr (synchronous)

Behaviour:
- Reset (sync, high) sets state=IDLE, WR=0, Ack=0, Grant=0, TxData=0, Busy=0, TimeoutErr=0, Ptr=0, timer=0. Reset has priority over all events, including mid-transaction. No Ack is issued for an aborted transfer.
- States: IDLE, WRITE, WAIT_LOW, WAIT_HIGH, ACK. WR, Ack and Busy are Moore decodes of state. Grant and TxData are registers.
- IDLE: if |Req && TxRDY==1, pick the winner by round robin. Search order is Ptr, Ptr+1, ... mod NREQ. Register Grant=onehot(winner), TxData=ReqData[winner], timer=0, then go to WRITE. If TxRDY==0 or no Req, stay in IDLE.
- WRITE: WR=1 for exactly one cycle, then go to WAIT_LOW.
- WAIT_LOW: if TxRDY==0, go to WAIT_HIGH. Otherwise timer++.
- WAIT_HIGH: if TxRDY==1, go to ACK. Otherwise timer++.
- Watchdog: in WAIT_LOW or WAIT_HIGH, when timer==TIMEOUT_CYC-1 and the exit condition is not met, set TimeoutErr=1 and go to ACK. The abort path still pulses Ack so the requester is not stranded.
- ACK: Ack=Grant for one cycle. Ptr <= (granted index + 1) mod NREQ. Go to IDLE. Grant clears to 0 on exit.
- Latency: Req sampled in IDLE -> WR at edge+1. Minimum Req-to-Ack is 4 cycles when TxRDY toggles immediately.
- Back-to-back transfers: IDLE is always visited for one cycle between transfers, so there is never a WR on consecutive cycles.
- Req deasserted after grant: ignored. The transfer completes with the latched data and Ack still pulses. Changes to ReqData after grant have no effect.
- Non-granted Req lines are ignored until the next IDLE arbitration. Starvation-free: any held Req is served within NREQ grants.
- TimeoutErr: set has priority over ClrErr in the same cycle. Otherwise ClrErr clears it. The flag does not block further arbitration.
- Timer width is clog2(TIMEOUT_CYC)+1. It never wraps, because it is cleared on entry to WRITE.
- Ptr width is clog2(NREQ). Ptr is updated only in ACK.

Test Plan:
- Single source: NREQ=4, Req=0100, ReqData[2]=8'hA5, TxRDY=1. Required: WR=1 one cycle after Req sampled, TxData=A5, Grant=0100, Busy=1. Bench then holds TxRDY low 3 cycles, then high. Required: Ack=0100 for exactly one cycle, one edge after TxRDY high is sampled.
- All four Req held high from reset, TxRDY model returns after 5 cycles. Required: grant order 0,1,2,3,0, one WR per transfer, never two WR in adjacent cycles.
- Ptr=2 (after serving source 1), Req=1010. Required: source 3 is granted first, then source 1.
- TIMEOUT_CYC=16, TxRDY stuck at 1 after WR. Required: Ack pulses 16 cycles after WAIT_LOW entry, TimeoutErr=1 and stays 1. ClrErr=1 for one cycle then clears it. A same-cycle set and ClrErr leaves the flag at 1.
- Req=0001 with TxRDY=0 in IDLE for 10 cycles. Required: no WR, Busy=0. TxRDY rises to 1. Required: WR on the next cycle.
- Reset asserted during WAIT_HIGH. Required: next edge gives all outputs 0 and state IDLE with no Ack. Following Req=0010 grants source 1 (search restarts from Ptr=0).
